glb_launch_ctrl: RTL and testbench
==================================

// Module: glb_launch_ctrl
// PURPOSE
//  Command-driven sequencer between a host/test driver and global_buffer. Executes one command at a time:
//  - GLB config-register writes and reads on if_cfg_*.
//  - Per-tile start pulses (strm_g2f/strm_f2g/pcfg).
//  - Waits for the matching per-tile interrupt pulses, with timeout.
//  Every command returns exactly one response. Clocked on the same clk as the GLB cfg interface.
// PARAMETERS
//  NUM_GLB_TILES   16      tiles; must be <= AXI_DATA_WIDTH
//  AXI_ADDR_WIDTH  12      if_cfg address width
//  AXI_DATA_WIDTH  32      if_cfg data width
//  TIMEOUT_CYCLES  65536   max cycles in RD_WAIT/WAIT_IRQ before error; counter is $clog2(TIMEOUT_CYCLES+1) bits
// PORTS
//  clk                   in   1    clock
//  reset                 in   1    synchronous, active-high
//  cmd_valid/cmd_ready   in/out 1  command handshake; transfer when both are high
//  cmd_op                in   2    0=CFG_WR 1=CFG_RD 2=START 3=WAIT
//  cmd_addr              in   AXI_ADDR_WIDTH  cfg address; for START/WAIT, [1:0] = kind (0=g2f 1=f2g 2=pcfg, 3=reserved)
//  cmd_data              in   AXI_DATA_WIDTH  write data; for START/WAIT, [NUM_GLB_TILES-1:0] = tile mask
//  rsp_valid/rsp_ready   out/in 1  response handshake
//  rsp_err               out  1    timeout or reserved kind
//  rsp_data              out  AXI_DATA_WIDTH  read data, or WAIT completed-tile mask, else 0
//  if_cfg_wr_en, if_cfg_wr_clk_en  out 1; if_cfg_wr_addr out AXI_ADDR_WIDTH; if_cfg_wr_data out AXI_DATA_WIDTH
//  if_cfg_rd_en, if_cfg_rd_clk_en  out 1; if_cfg_rd_addr out AXI_ADDR_WIDTH
//  if_cfg_rd_data        in   AXI_DATA_WIDTH; if_cfg_rd_data_valid in 1
//  strm_g2f_start_pulse, strm_f2g_start_pulse, pcfg_start_pulse  out NUM_GLB_TILES
//  strm_g2f_interrupt_pulse, strm_f2g_interrupt_pulse, pcfg_g2f_interrupt_pulse  in NUM_GLB_TILES
//  busy                  out  1    state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; pending regs=0; all outputs 0 except cmd_ready=1.
//  cmd_ready=1 only in IDLE. A command is latched on the accept edge.
//  FSM states: IDLE, WR_PRE, WR, RD_PRE, RD, RD_WAIT, PULSE, WAIT_IRQ, RSP.
//  - CFG_WR: WR_PRE (wr_clk_en=1, wr_en=0), then WR (wr_clk_en=1, wr_en=1), then RSP. Addr/data are held through both cycles.
//  - CFG_RD: RD_PRE (rd_clk_en=1), then RD (rd_clk_en=1, rd_en=1), then RD_WAIT (rd_clk_en=1).
//    rd_data_valid seen -> capture rd_data into rsp_data, go to RSP.
//    rd_data_valid in the same cycle as RD (0-latency) is also accepted.
//    Timeout -> rsp_err=1, rsp_data=0.
//  - START: PULSE asserts the selected *_start_pulse = mask for exactly 1 cycle, then RSP.
//    Mask 0 -> no pulse.
//  - WAIT: WAIT_IRQ until (pending[kind] & mask) == mask, then RSP.
//    rsp_data = mask; the masked pending bits are cleared on exit. Mask 0 completes after 1 cycle.
//    Timeout -> rsp_err=1, rsp_data = pending&mask; pending is left intact.
//  - Reserved kind (3) for START/WAIT: no pulse, straight to RSP with rsp_err=1.
//  Pending regs (3 x NUM_GLB_TILES):
//  - Sticky OR of the interrupt pulses, captured in every state.
//    An interrupt arriving before its WAIT is therefore not lost.
//  - A START pulse clears pending[kind] bits for the masked tiles. If a clear and an interrupt hit the same bit in one cycle, the clear wins.
//  Timeout counter: zeroed on entry to RD_WAIT/WAIT_IRQ, increments each cycle in those states.
//  Timeout fires when count == TIMEOUT_CYCLES-1 and the completion condition is false that cycle.
//  Completion wins when both happen in the same cycle.
//  RSP: rsp_valid=1; rsp_data and rsp_err are held stable until rsp_ready. The handshake cycle returns to IDLE.
//  The next command can be accepted 1 cycle later.
//  Reset asserted mid-command:
//  - Aborts immediately; no further wr_en/rd_en or pulse is issued.
//  - Any pending response is discarded; pending regs are cleared.
//  if_cfg_* addr/data are 0 whenever the corresponding clk_en is 0.
// TESTING
//  1. Reset 5 cycles mid-WR_PRE -> wr_en never asserts; cmd_ready=1 and all pulses 0 the cycle after reset drops.
//  2. CFG_WR addr=0x010, data=0xDEADBEEF, rsp_ready=1:
//     -> wr_clk_en high 2 cycles, wr_en high on the 2nd only; rsp_valid 1 cycle later, rsp_err=0.
//  3. CFG_RD addr=0x024, GLB returns 0x1234 after 3 cycles -> rsp_data=0x1234.
//     Same read with no valid -> rsp_err=1 after TIMEOUT_CYCLES.
//  4. START kind=0, mask=0x0005 -> strm_g2f_start_pulse=0x0005 for exactly 1 cycle.
//     Then WAIT kind=0, mask=0x0005; interrupts on tile 0 then tile 2 -> rsp_data=0x0005 the cycle after tile 2's pulse.
//  5. Interrupt pcfg tile 3 arrives while idle, then WAIT kind=2, mask=0x0008 -> completes without any further interrupt.
//     Interrupt coincident with START clear on the same tile -> the following WAIT times out.
//  6. rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable and cmd_ready=0 throughout.
//     START kind=3 -> rsp_err=1 and no pulse.

Source files
------------

// File: rtl/glb_launch_ctrl.sv
// Command sequencer for the global_buffer: drives cfg register writes/reads,
// issues per-tile start pulses and waits on per-tile interrupts with a timeout.
module glb_launch_ctrl #(
  parameter int NUM_GLB_TILES  = 16,
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0] cmd_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_err,
  output logic [AXI_DATA_WIDTH-1:0] rsp_data,
  output logic                      if_cfg_wr_en,
  output logic                      if_cfg_wr_clk_en,
  output logic [AXI_ADDR_WIDTH-1:0] if_cfg_wr_addr,
  output logic [AXI_DATA_WIDTH-1:0] if_cfg_wr_data,
  output logic                      if_cfg_rd_en,
  output logic                      if_cfg_rd_clk_en,
  output logic [AXI_ADDR_WIDTH-1:0] if_cfg_rd_addr,
  input  logic [AXI_DATA_WIDTH-1:0] if_cfg_rd_data,
  input  logic                      if_cfg_rd_data_valid,
  output logic [NUM_GLB_TILES-1:0]  strm_g2f_start_pulse,
  output logic [NUM_GLB_TILES-1:0]  strm_f2g_start_pulse,
  output logic [NUM_GLB_TILES-1:0]  pcfg_start_pulse,
  input  logic [NUM_GLB_TILES-1:0]  strm_g2f_interrupt_pulse,
  input  logic [NUM_GLB_TILES-1:0]  strm_f2g_interrupt_pulse,
  input  logic [NUM_GLB_TILES-1:0]  pcfg_g2f_interrupt_pulse,
  output logic                      busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam int unsigned NK = 3;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PRE, S_WR, S_RD_PRE, S_RD, S_RD_WAIT, S_PULSE, S_WAIT_IRQ, S_RSP
  } state_e;

  typedef enum logic [1:0] {OP_CFG_WR, OP_CFG_RD, OP_START, OP_WAIT} op_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [NUM_GLB_TILES-1:0]  pend_q [NK];
  logic [NUM_GLB_TILES-1:0]  pend_d [NK];
  logic [NUM_GLB_TILES-1:0]  irq    [NK];
  logic [NUM_GLB_TILES-1:0]  pulse  [NK];
  logic [NUM_GLB_TILES-1:0]  mask, seen;
  logic [1:0]                kind;
  logic                      accept, done, expired;

  assign irq[0] = strm_g2f_interrupt_pulse;
  assign irq[1] = strm_f2g_interrupt_pulse;
  assign irq[2] = pcfg_g2f_interrupt_pulse;

  assign strm_g2f_start_pulse = pulse[0];
  assign strm_f2g_start_pulse = pulse[1];
  assign pcfg_start_pulse     = pulse[2];

  assign kind     = addr_q[1:0];
  assign mask     = data_q[NUM_GLB_TILES-1:0];
  assign accept   = cmd_valid & cmd_ready;
  assign rsp_err  = rsp_err_q;
  assign rsp_data = rsp_data_q;

  // Interrupts arriving this cycle count toward completion immediately.
  always_comb begin
    seen = '0;
    for (int unsigned k = 0; k < NK; k++) begin
      if (kind == 2'(k)) seen = pend_q[k] | irq[k];
    end
  end

  assign done    = ((seen & mask) == mask);
  assign expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d          = state_q;
    cnt_d            = '0;
    rsp_err_d        = rsp_err_q;
    rsp_data_d       = rsp_data_q;
    cmd_ready        = 1'b0;
    rsp_valid        = 1'b0;
    if_cfg_wr_en     = 1'b0;
    if_cfg_wr_clk_en = 1'b0;
    if_cfg_wr_addr   = '0;
    if_cfg_wr_data   = '0;
    if_cfg_rd_en     = 1'b0;
    if_cfg_rd_clk_en = 1'b0;
    if_cfg_rd_addr   = '0;
    for (int unsigned k = 0; k < NK; k++) begin
      pend_d[k] = pend_q[k] | irq[k];
      pulse[k]  = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          rsp_err_d  = 1'b0;
          rsp_data_d = '0;
          unique case (op_e'(cmd_op))
            OP_CFG_WR: state_d = S_WR_PRE;
            OP_CFG_RD: state_d = S_RD_PRE;
            OP_START, OP_WAIT: begin
              if (cmd_addr[1:0] == 2'd3) begin
                rsp_err_d = 1'b1;
                state_d   = S_RSP;
              end else begin
                state_d = (op_e'(cmd_op) == OP_START) ? S_PULSE : S_WAIT_IRQ;
              end
            end
          endcase
        end
      end
      S_WR_PRE, S_WR: begin
        if_cfg_wr_clk_en = 1'b1;
        if_cfg_wr_addr   = addr_q;
        if_cfg_wr_data   = data_q;
        if_cfg_wr_en     = (state_q == S_WR);
        state_d          = (state_q == S_WR) ? S_RSP : S_WR;
      end
      S_RD_PRE: begin
        if_cfg_rd_clk_en = 1'b1;
        if_cfg_rd_addr   = addr_q;
        state_d          = S_RD;
      end
      S_RD, S_RD_WAIT: begin
        if_cfg_rd_clk_en = 1'b1;
        if_cfg_rd_addr   = addr_q;
        if_cfg_rd_en     = (state_q == S_RD);
        if (state_q == S_RD_WAIT) cnt_d = cnt_q + CW'(1);
        if (if_cfg_rd_data_valid) begin
          rsp_data_d = if_cfg_rd_data;
          state_d    = S_RSP;
        end else if (state_q == S_RD) begin
          state_d = S_RD_WAIT;
        end else if (expired) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = S_RSP;
        end
      end
      S_PULSE: begin
        for (int unsigned k = 0; k < NK; k++) begin
          if (kind == 2'(k)) begin
            pulse[k]  = mask;
            pend_d[k] = pend_d[k] & ~mask;
          end
        end
        state_d = S_RSP;
      end
      S_WAIT_IRQ: begin
        cnt_d = cnt_q + CW'(1);
        if (done) begin
          rsp_data_d = AXI_DATA_WIDTH'(mask);
          for (int unsigned k = 0; k < NK; k++) begin
            if (kind == 2'(k)) pend_d[k] = pend_d[k] & ~mask;
          end
          state_d = S_RSP;
        end else if (expired) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = AXI_DATA_WIDTH'(seen & mask);
          state_d    = S_RSP;
        end
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset masks strobes in the same cycle so an aborted command issues nothing more.
    if (reset) begin
      cmd_ready        = 1'b1;
      rsp_valid        = 1'b0;
      if_cfg_wr_en     = 1'b0;
      if_cfg_wr_clk_en = 1'b0;
      if_cfg_wr_addr   = '0;
      if_cfg_wr_data   = '0;
      if_cfg_rd_en     = 1'b0;
      if_cfg_rd_clk_en = 1'b0;
      if_cfg_rd_addr   = '0;
      for (int unsigned k = 0; k < NK; k++) pulse[k] = '0;
    end
  end

  assign busy = (state_q != S_IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
      for (int unsigned k = 0; k < NK; k++) pend_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
      for (int unsigned k = 0; k < NK; k++) pend_q[k] <= pend_d[k];
      if (accept) begin
        addr_q <= cmd_addr;
        data_q <= cmd_data;
      end
    end
  end

endmodule

// File: tb/tb_glb_launch_ctrl.sv
// Randomized self-checking bench for glb_launch_ctrl against a transaction-level model.
module tb_glb_launch_ctrl;
  localparam int N  = 16;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int T  = 16;
  localparam int NEVER = 1000;

  typedef int sched_t [N];

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_data;
  logic          wr_en, wr_clk_en, rd_en, rd_clk_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_data_valid;
  logic [N-1:0]  g2f_sp, f2g_sp, pcfg_sp;
  logic          busy;

  logic [N-1:0]  irq_v  [3];
  logic [N-1:0]  clr_m  [3];
  logic [N-1:0]  pend_m [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  glb_launch_ctrl #(
    .NUM_GLB_TILES (N),
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_op                  (cmd_op),
    .cmd_addr                (cmd_addr),
    .cmd_data                (cmd_data),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_err                 (rsp_err),
    .rsp_data                (rsp_data),
    .if_cfg_wr_en            (wr_en),
    .if_cfg_wr_clk_en        (wr_clk_en),
    .if_cfg_wr_addr          (wr_addr),
    .if_cfg_wr_data          (wr_data),
    .if_cfg_rd_en            (rd_en),
    .if_cfg_rd_clk_en        (rd_clk_en),
    .if_cfg_rd_addr          (rd_addr),
    .if_cfg_rd_data          (rd_data),
    .if_cfg_rd_data_valid    (rd_data_valid),
    .strm_g2f_start_pulse    (g2f_sp),
    .strm_f2g_start_pulse    (f2g_sp),
    .pcfg_start_pulse        (pcfg_sp),
    .strm_g2f_interrupt_pulse(irq_v[0]),
    .strm_f2g_interrupt_pulse(irq_v[1]),
    .pcfg_g2f_interrupt_pulse(irq_v[2]),
    .busy                    (busy)
  );

  task automatic check_eq(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: fold driven interrupts and START clears into the model, then advance.
  task automatic tick();
    for (int k = 0; k < 3; k++) pend_m[k] = (pend_m[k] | irq_v[k]) & ~clr_m[k];
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      irq_v[k] = '0;
      clr_m[k] = '0;
    end
    rd_data_valid = 1'b0;
  endtask

  function automatic logic [N-1:0] pulse_of(int k);
    case (k)
      0:       return g2f_sp;
      1:       return f2g_sp;
      default: return pcfg_sp;
    endcase
  endfunction

  task automatic idle_gap();
    int g;
    g = $urandom_range(0, 2);
    repeat (g) begin
      for (int k = 0; k < 3; k++) irq_v[k] = N'($urandom & $urandom & $urandom);
      tick();
    end
  endtask

  task automatic send(logic [1:0] op, logic [AW-1:0] addr, logic [DW-1:0] data);
    check_eq("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = AW'($urandom);
    cmd_data  = $urandom;
  endtask

  task automatic finish_rsp(logic exp_err, logic [DW-1:0] exp_data, int hold);
    check_eq("rsp_valid", rsp_valid, 1);
    check_eq("rsp_err", rsp_err, exp_err);
    check_eq("rsp_data", rsp_data, exp_data);
    if (hold > 0) begin
      rsp_ready = 1'b0;
      repeat (hold) begin
        tick();
        check_eq("hold_rsp_valid", rsp_valid, 1);
        check_eq("hold_rsp_data", rsp_data, exp_data);
        check_eq("hold_rsp_err", rsp_err, exp_err);
        check_eq("hold_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
    end
    tick();
    check_eq("post_rsp_valid", rsp_valid, 0);
    check_eq("post_busy", busy, 0);
  endtask

  task automatic cfg_wr(logic [AW-1:0] addr, logic [DW-1:0] data, int hold);
    int n = 0;
    send(2'd0, addr, data);
    while (rsp_valid !== 1'b1 && n < 8) begin
      check_eq("wr_clk_en", wr_clk_en, 1);
      check_eq("wr_en", wr_en, (n == 1));
      check_eq("wr_addr", wr_addr, addr);
      check_eq("wr_data", wr_data, data);
      check_eq("wr_rd_clk_en", rd_clk_en, 0);
      tick();
      n++;
    end
    check_eq("wr_latency", n, 2);
    check_eq("wr_idle_clk_en", wr_clk_en, 0);
    check_eq("wr_idle_addr", wr_addr, 0);
    finish_rsp(1'b0, '0, hold);
  endtask

  // lat: cycles after the rd_en cycle before valid is returned; negative = never.
  task automatic cfg_rd(logic [AW-1:0] addr, int lat, logic [DW-1:0] rdata, int hold);
    int  n = 0;
    int  exp_n;
    bit  ok;
    ok    = (lat >= 0) && (lat <= T);
    exp_n = ok ? 2 + lat : 2 + T;
    send(2'd1, addr, $urandom);
    while (rsp_valid !== 1'b1 && n < T + 8) begin
      check_eq("rd_clk_en", rd_clk_en, 1);
      check_eq("rd_en", rd_en, (n == 1));
      check_eq("rd_addr", rd_addr, addr);
      rd_data = $urandom;
      if (lat >= 0 && n == 1 + lat) begin
        rd_data       = rdata;
        rd_data_valid = 1'b1;
      end
      tick();
      n++;
    end
    check_eq("rd_latency", n, exp_n);
    check_eq("rd_idle_addr", rd_addr, 0);
    finish_rsp(!ok, ok ? rdata : '0, hold);
  endtask

  task automatic start_cmd(int kind, logic [N-1:0] mask, logic [N-1:0] coinc, int hold);
    logic [AW-1:0] a;
    a = (AW'($urandom) & ~AW'(3)) | AW'(kind);
    send(2'd2, a, {DW'($urandom) & ~DW'({N{1'b1}})} | DW'(mask));
    if (kind == 3) begin
      for (int k = 0; k < 3; k++) check_eq("rsvd_no_pulse", pulse_of(k), 0);
      finish_rsp(1'b1, '0, hold);
      return;
    end
    for (int k = 0; k < 3; k++) check_eq("start_pulse", pulse_of(k), (k == kind) ? mask : '0);
    irq_v[kind] = coinc;
    clr_m[kind] = mask;
    tick();
    for (int k = 0; k < 3; k++) check_eq("pulse_one_cycle", pulse_of(k), 0);
    finish_rsp(1'b0, '0, hold);
  endtask

  task automatic wait_cmd(int kind, logic [N-1:0] mask, sched_t sched, int hold);
    logic [N-1:0]  acc;
    logic [DW-1:0] exp_data;
    int            exp_i = -1;
    int            exp_n;
    int            n = 0;
    send(2'd3, (AW'($urandom) & ~AW'(3)) | AW'(kind), DW'(mask));
    if (kind == 3) begin
      finish_rsp(1'b1, '0, hold);
      return;
    end
    acc = pend_m[kind];
    for (int i = 0; i < T; i++) begin
      for (int t = 0; t < N; t++) if (mask[t] && sched[t] == i) acc[t] = 1'b1;
      if ((acc & mask) == mask) begin
        exp_i = i;
        break;
      end
    end
    exp_n    = (exp_i >= 0) ? exp_i + 1 : T;
    exp_data = (exp_i >= 0) ? DW'(mask) : DW'(acc & mask);
    while (rsp_valid !== 1'b1 && n < T + 4) begin
      for (int t = 0; t < N; t++) irq_v[kind][t] = mask[t] && (sched[t] == n);
      tick();
      n++;
    end
    check_eq("wait_latency", n, exp_n);
    if (exp_i >= 0) pend_m[kind] = pend_m[kind] & ~mask;
    finish_rsp(exp_i < 0, exp_data, hold);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    sched_t s;
    int     op, hold, kind, lat;
    logic [N-1:0] m;

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b1; rd_data = '0; rd_data_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      irq_v[k] = '0; clr_m[k] = '0; pend_m[k] = '0;
    end
    repeat (3) tick();
    reset = 1'b0;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wr_clk_en", wr_clk_en, 0);
    check_eq("rst_rd_clk_en", rd_clk_en, 0);

    // Reset mid WR_PRE with a g2f interrupt already pending.
    irq_v[0] = N'(16'h0080);
    tick();
    send(2'd0, 12'h010, 32'hDEADBEEF);
    check_eq("abort_wr_clk_en", wr_clk_en, 1);
    reset = 1'b1;
    check_eq("abort_wr_en", wr_en, 0);
    repeat (5) begin
      tick();
      check_eq("abort_wr_en", wr_en, 0);
      check_eq("abort_rsp_valid", rsp_valid, 0);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) pend_m[k] = '0;
    tick();
    check_eq("abort_cmd_ready", cmd_ready, 1);
    check_eq("abort_wr_en2", wr_en, 0);
    for (int k = 0; k < 3; k++) check_eq("abort_pulse", pulse_of(k), 0);
    for (int t = 0; t < N; t++) s[t] = NEVER;
    wait_cmd(0, N'(16'h0080), s, 0);

    cfg_wr(12'h010, 32'hDEADBEEF, 0);
    cfg_rd(12'h024, 3, 32'h0000_1234, 0);
    cfg_rd(12'h024, -1, 32'h0, 0);
    cfg_rd(12'h024, 0, 32'hCAFE_0001, 0);

    start_cmd(0, N'(16'h0005), '0, 0);
    s[0] = 1; s[2] = 3;
    wait_cmd(0, N'(16'h0005), s, 0);
    for (int t = 0; t < N; t++) s[t] = NEVER;

    irq_v[2] = N'(16'h0008);
    tick();
    wait_cmd(2, N'(16'h0008), s, 0);
    start_cmd(1, N'(16'h0002), N'(16'h0002), 0);
    wait_cmd(1, N'(16'h0002), s, 0);
    wait_cmd(0, '0, s, 0);

    cfg_rd(12'h100, 2, 32'hA5A5_5A5A, 10);
    start_cmd(3, N'(16'hFFFF), '0, 0);
    wait_cmd(3, N'(16'h0001), s, 2);

    for (int it = 0; it < 60; it++) begin
      idle_gap();
      op   = $urandom_range(0, 3);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      kind = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      case (op)
        0: cfg_wr(AW'($urandom), $urandom, hold);
        1: begin
          lat = $urandom_range(0, 9);
          if (lat == 9) lat = -1;
          else if (lat == 8) lat = T;
          else if (lat == 7) lat = T + 1;
          cfg_rd(AW'($urandom), lat, $urandom, hold);
        end
        2: start_cmd(kind, N'($urandom), N'($urandom & $urandom), hold);
        default: begin
          m = N'($urandom & $urandom & $urandom);
          for (int t = 0; t < N; t++) s[t] = $urandom_range(0, T + 3);
          wait_cmd(kind, m, s, hold);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
